// File: rtl/pc_pkg.sv
// Shared definitions for the program counter unit: instruction size,
// FSM state encoding and the next-PC source selector.
package pc_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } state_t;

  typedef enum logic [2:0] {
    NPC_EXC,
    NPC_BR,
    NPC_RET,
    NPC_ADV,
    NPC_HOLD
  } npc_src_t;

endpackage

// File: rtl/pc_unit_if.sv
// Fetch handshake between the PC unit (master) and the instruction fetcher (slave).
interface pc_unit_if #(
  parameter int XLEN = 32
) ();

  logic            pc_valid;
  logic            pc_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;

  modport master (output pc_valid, output pc, output npc, input pc_ready);
  modport slave  (input pc_valid, input pc, input npc, output pc_ready);

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest
// entry, and a simultaneous push/pop replaces the top entry in place.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(RAS_DEPTH));
  assign top    = mem[sp];
  assign do_pop = pop && !empty;

  // sp always indexes the newest entry; wrapping sp on overflow drops the oldest
  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
    end else if (push && do_pop) begin
      mem[sp] <= push_data;
    end else if (push) begin
      mem[sp + 1'b1] <= push_data;
      sp             <= sp + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (do_pop) begin
      sp    <= sp - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: fetch handshake plus exception/branch/return redirects.
// The return-address stack is built only when PC_UNIT_RAS_EN is defined.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_3000,
  parameter int              RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_target,
  input  logic             exc_valid,
  input  logic [XLEN-1:0]  exc_vec,
  input  logic             call_push,
  input  logic             ret_pop,
  output logic             ras_empty,
  output logic             ras_miss,
  pc_unit_if.master        fetch
);

  state_t          state, state_next;
  npc_src_t        npc_src;
  logic [XLEN-1:0] pc_q, npc, pc_inc, ras_top;
  logic            ras_hit, advance;

  assign pc_inc = pc_q + XLEN'(INSTR_BYTES);

`ifdef PC_UNIT_RAS_EN
  logic ras_push, ras_pop, ras_full, unused_ras_full;

  // an exception in the same cycle cancels any stack activity
  assign ras_push = call_push && !exc_valid;
  assign ras_pop  = ret_pop && !exc_valid;
  assign ras_hit  = ras_pop && !ras_empty;
  assign unused_ras_full = ras_full;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk) begin
    if (rst) ras_miss <= 1'b0;
    else     ras_miss <= ras_pop && ras_empty;
  end
`else
  logic unused_ras_req;

  assign unused_ras_req = call_push | ret_pop;
  assign ras_top   = '0;
  assign ras_hit   = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_miss  = 1'b0;
`endif

  always_comb begin
    advance    = (state != BOOT) && fetch.pc_ready && !stall;
    npc_src    = NPC_HOLD;
    npc        = pc_q;
    state_next = state;

    if (exc_valid)     npc_src = NPC_EXC;
    else if (br_valid) npc_src = NPC_BR;
    else if (ras_hit)  npc_src = NPC_RET;
    else if (advance)  npc_src = NPC_ADV;

    case (npc_src)
      NPC_EXC: npc = exc_vec;
      NPC_BR:  npc = br_target;
      NPC_RET: npc = ras_top;
      NPC_ADV: npc = pc_inc;
      default: npc = pc_q;
    endcase

    // HOLD exactly when nothing moves the PC: backpressure or stall without redirect
    case (state)
      BOOT:      state_next = RUN;
      RUN, HOLD: state_next = (npc_src == NPC_HOLD) ? HOLD : RUN;
      default:   state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc_q  <= RESET_VEC;
    end else begin
      state <= state_next;
      pc_q  <= npc;
    end
  end

  assign fetch.pc       = pc_q;
  assign fetch.npc      = npc;
  assign fetch.pc_valid = (state != BOOT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_pc_unit;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_VEC = 32'h0000_3000;
  localparam int          RAS_DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, br_valid, exc_valid, call_push, ret_pop;
  logic [31:0] br_target, exc_vec;
  logic        ras_empty, ras_miss;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_miss;
  logic [31:0] m_stack[$];

  pc_unit_if #(.XLEN(XLEN)) fetch ();

  pc_unit #(
    .XLEN      (XLEN),
    .RESET_VEC (RESET_VEC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .exc_valid (exc_valid),
    .exc_vec   (exc_vec),
    .call_push (call_push),
    .ret_pop   (ret_pop),
    .ras_empty (ras_empty),
    .ras_miss  (ras_miss),
    .fetch     (fetch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rdy,
                               input logic bv, input logic [31:0] bt,
                               input logic ev, input logic [31:0] evec,
                               input logic cp, input logic rp);
    rst = r; stall = s; fetch.pc_ready = rdy;
    br_valid = bv; br_target = bt;
    exc_valid = ev; exc_vec = evec;
    call_push = cp; ret_pop = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  // Reference: next PC from the priority rules applied to the model state
  function automatic logic [31:0] model_npc();
    if (exc_valid) return exc_vec;
    if (br_valid) return br_target;
    if (RAS_ON && ret_pop && m_stack.size() > 0) return m_stack[$];
    if (!m_boot && fetch.pc_ready && !stall) return m_pc + 32'd4;
    return m_pc;
  endfunction

  always @(posedge clk) begin
    logic [31:0] nxt;
    if (rst) begin
      m_pc   = RESET_VEC;
      m_boot = 1'b1;
      m_miss = 1'b0;
      m_stack.delete();
    end else begin
      nxt    = model_npc();
      m_miss = RAS_ON && ret_pop && !exc_valid && (m_stack.size() == 0);
      if (RAS_ON && !exc_valid) begin
        if (ret_pop && m_stack.size() > 0) void'(m_stack.pop_back());
        if (call_push) begin
          m_stack.push_back(m_pc + 32'd4);
          if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
        end
      end
      m_pc   = nxt;
      m_boot = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_pc", fetch.pc, m_pc);
      checkOutput("cyc_pc_valid", {31'b0, fetch.pc_valid}, {31'b0, !m_boot});
      checkOutput("cyc_npc", fetch.npc, model_npc());
      checkOutput("cyc_ras_empty", {31'b0, ras_empty}, {31'b0, (!RAS_ON) || (m_stack.size() == 0)});
      checkOutput("cyc_ras_miss", {31'b0, ras_miss}, {31'b0, m_miss});
    end
  end

  initial begin
    logic [31:0] pop_on [5];
    logic [31:0] pop_off [5];
    pop_on  = '{32'h4194, 32'h4190, 32'h418C, 32'h4188, 32'h418C};
    pop_off = '{32'h4198, 32'h419C, 32'h41A0, 32'h41A4, 32'h41A8};

    applyStimulus(1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    check_en = 1'b1;
    checkOutput("reset_pc", fetch.pc, 32'h0000_3000);
    checkOutput("reset_valid", {31'b0, fetch.pc_valid}, 32'd0);
    checkOutput("reset_ras_empty", {31'b0, ras_empty}, 32'd1);
    checkOutput("reset_ras_miss", {31'b0, ras_miss}, 32'd0);
    idle();
    checkOutput("boot_valid", {31'b0, fetch.pc_valid}, 32'd1);
    checkOutput("boot_pc", fetch.pc, 32'h0000_3000);

    idle();
    idle();
    checkOutput("adv_pc", fetch.pc, 32'h3008);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
      checkOutput("bp_hold_pc", fetch.pc, 32'h3008);
    end
    idle();
    checkOutput("bp_release_pc", fetch.pc, 32'h300C);

    idle();
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 1, 1, 32'h6000, 0, 32'h0, 0, 0);
    checkOutput("br_pc", fetch.pc, 32'h6000);
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 1);
    checkOutput("ret_pc", fetch.pc, RAS_ON ? 32'h3014 : 32'h6004);
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 1);
    checkOutput("ret_empty_pc", fetch.pc, RAS_ON ? 32'h3018 : 32'h6008);
    checkOutput("ret_empty_miss", {31'b0, ras_miss}, {31'b0, RAS_ON});
    idle();
    checkOutput("miss_pulse_end", {31'b0, ras_miss}, 32'd0);

    applyStimulus(0, 1, 1, 1, 32'h5000, 1, 32'h4180, 0, 0);
    checkOutput("prio_exc_pc", fetch.pc, 32'h4180);

    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0);
    checkOutput("push5_pc", fetch.pc, 32'h4194);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 1);
      checkOutput("ovf_pop_pc", fetch.pc, RAS_ON ? pop_on[i] : pop_off[i]);
    end
    checkOutput("ovf_miss", {31'b0, ras_miss}, {31'b0, RAS_ON});
    idle();

    applyStimulus(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0);
    checkOutput("wrap_pre", fetch.pc, 32'hFFFF_FFFC);
    idle();
    checkOutput("wrap_pc", fetch.pc, 32'h0000_0000);

    applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    applyStimulus(1, 1, 0, 1, 32'h7000, 1, 32'h8000, 1, 1);
    checkOutput("rst_prio_pc", fetch.pc, 32'h0000_3000);
    checkOutput("rst_prio_valid", {31'b0, fetch.pc_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) != 0,
                    $urandom_range(7) == 0, $urandom,
                    $urandom_range(15) == 0, $urandom,
                    $urandom_range(5) == 0, $urandom_range(5) == 0);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_3000, PC value loaded by reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port stall  input  1  hold PC; no sequential advance.
REQ-007 SHALL have ports br_valid  input  1 and br_target  input  XLEN  branch/jump redirect.
REQ-008 SHALL have ports exc_valid  input  1 and exc_vec  input  XLEN  exception redirect.
REQ-009 SHALL have ports call_push  input  1 and ret_pop  input  1  RAS push/pop requests.
REQ-010 SHALL have ports pc_valid  output  1, pc_ready  input  1 and pc  output  XLEN  fetch handshake.
REQ-011 SHALL have port npc  output  XLEN  next PC, combinational.
REQ-012 SHALL have ports ras_empty  output  1 and ras_miss  output  1  stack status / one-cycle pop-on-empty pulse.

Function
REQ-013 SHALL implement FSM states BOOT, RUN, HOLD; BOOT after reset, BOOT->RUN unconditionally next cycle.
REQ-014 SHALL drive pc_valid=0 in BOOT, 1 in RUN and HOLD.
REQ-015 SHALL select npc by fixed priority: exc_valid > br_valid > ret_pop (RAS non-empty) > advance > hold.
REQ-016 SHALL define advance as state RUN/HOLD, pc_valid&&pc_ready, stall=0; advance gives npc=pc+4, modulo 2^XLEN (wrap, no flag).
REQ-017 SHALL update pc<=npc every cycle; redirects (exc, br, ret) take effect next cycle regardless of pc_ready or stall.
REQ-018 SHALL enter HOLD when pc_valid&&!pc_ready, or stall, with no redirect; return to RUN on the first advance or redirect.
REQ-019 SHALL hold pc stable in HOLD (valid/data stable until handshake completes) unless a redirect arrives.
REQ-020 SHALL, on call_push, push pc+4 (of current pc) onto the RAS in the same cycle; full stack overwrites oldest entry (circular).
REQ-021 SHALL, on ret_pop with stack non-empty, set npc to top entry and pop it; with stack empty, pulse ras_miss for one cycle and fall through to next priority.
REQ-022 SHALL, on simultaneous call_push and ret_pop, perform pop-then-push (top replaced, depth unchanged).
REQ-023 SHALL ignore call_push/ret_pop (no stack change) when exc_valid=1 in the same cycle.
REQ-024 SHALL treat br_target/exc_vec bits [1:0] as-is (no alignment forcing).

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set pc=RESET_VEC, state=BOOT, pc_valid=0, RAS count=0, ras_empty=1, ras_miss=0.
REQ-026 SHALL give rst priority over every other input, including mid-HOLD and mid-redirect.

Configuration
REQ-027 SHALL compile the RAS only when macro PC_UNIT_RAS_EN is defined.
REQ-028 SHALL, without PC_UNIT_RAS_EN, ignore call_push/ret_pop, tie ras_empty=1 and ras_miss=0, with no RAS storage.

Structure
REQ-029 SHALL place INSTR_BYTES (4), state encodings (BOOT/RUN/HOLD) and the npc-source enum in shared package pc_pkg.
REQ-030 SHALL implement the RAS as sub-module pc_ras (push, pop, top, empty, full; parametrised XLEN, RAS_DEPTH).

Verification
REQ-031 SHALL cover reset: rst=1 one cycle -> pc=32'h0000_3000, pc_valid=0; next cycle pc_valid=1, pc unchanged.
REQ-032 SHALL cover backpressure: pc_ready=0 three cycles at pc=0x3008 -> pc stays 0x3008, state HOLD; pc_ready=1 -> 0x300C.
REQ-033 SHALL cover priority: exc_valid (exc_vec=0x4180) and br_valid (br_target=0x5000) together with stall=1 -> pc=0x4180 next cycle.
REQ-034 SHALL cover RAS: call_push at pc=0x3010, br to 0x6000, ret_pop -> pc=0x3014; extra ret_pop on empty -> ras_miss=1 one cycle, pc=+4.
REQ-035 SHALL cover RAS overflow: five pushes with RAS_DEPTH=4 -> four pops return newest four, fifth pop raises ras_miss.
REQ-036 SHALL cover wrap: pc=32'hFFFF_FFFC advance -> pc=32'h0000_0000.
